// File: rtl/ama_riscv_rf_wb_arbiter_pkg.sv
// Shared register-file types and helpers for the writeback arbiter slice.
// wb_rsp_t is one buffered long-latency response.
package ama_riscv_rf_wb_arbiter_pkg;

    localparam int RF_NUM     = 32;
    localparam int ARCH_WIDTH = 32;
    localparam int RF_ADDR_W  = 5;

    typedef logic [RF_ADDR_W-1:0]  rf_addr_t;
    typedef logic [ARCH_WIDTH-1:0] arch_width_t;

    localparam rf_addr_t RF_X0_ZERO = 5'd0;
    localparam rf_addr_t RF_X31_T6  = 5'd31;

    typedef struct packed {
        rf_addr_t    rd;
        logic        pair;
        arch_width_t data;
        arch_width_t data_p;
    } wb_rsp_t;

    // Paired destination is the next register up; x31 has no legal pair.
    function automatic rf_addr_t get_rdp(input rf_addr_t rd);
        return rd + rf_addr_t'(1);
    endfunction

endpackage

// File: rtl/ama_riscv_wb_fifo.sv
// Synchronous in-order FIFO of writeback responses.
// Reset clears only the pointers; storage holds no control state.
module ama_riscv_wb_fifo
    import ama_riscv_rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_rsp_t din,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_rsp_t head
);

    localparam int PW = $clog2(DEPTH);

    wb_rsp_t        mem [DEPTH];
    logic    [PW:0] wr_ptr;
    logic    [PW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/ama_riscv_rf_wb_arbiter.sv
// Register-file write-port owner: pipeline writeback has priority, buffered
// long-latency responses drain into bubbles; tracks pending destinations.
module ama_riscv_rf_wb_arbiter
    import ama_riscv_rf_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic        pipe_we_p,
    input  rf_addr_t    pipe_rd,
    input  arch_width_t pipe_data,
    input  arch_width_t pipe_data_p,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  rf_addr_t    iss_rd,
    input  logic        iss_pair,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  rf_addr_t    rsp_rd,
    input  logic        rsp_pair,
    input  arch_width_t rsp_data,
    input  arch_width_t rsp_data_p,
    input  rf_addr_t    chk_addr_a,
    input  rf_addr_t    chk_addr_b,
    output logic        busy_a,
    output logic        busy_b,
    output logic        rf_we,
    output logic        rf_we_p,
    output rf_addr_t    rf_addr_d,
    output arch_width_t rf_data_d,
    output arch_width_t rf_data_dp
);

    localparam int OW = $clog2(MAX_OUTST + 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              iss_fire;
    wb_rsp_t           rsp_in;
    wb_rsp_t           head;
    logic [RF_NUM-1:0] pending;
    logic [RF_NUM-1:0] pending_nxt;
    logic [OW-1:0]     outst;

    assign rsp_in = '{rd: rsp_rd, pair: rsp_pair, data: rsp_data, data_p: rsp_data_p};

    ama_riscv_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rsp_in),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // rsp_ready looks only at registered fullness, never at a same-cycle pop.
    assign rsp_ready = !rst && !fifo_full;
    assign push      = rsp_valid && rsp_ready;
    assign pop       = !rst && !pipe_we && !fifo_empty;

    // A clear landing this cycle does not unblock; the issuer retries next cycle.
    assign iss_ready = !rst && (outst < OW'(MAX_OUTST)) && !pending[iss_rd]
                       && !(iss_pair && pending[get_rdp(iss_rd)]);
    assign iss_fire  = iss_valid && iss_ready;

    assign busy_a = !rst && pending[chk_addr_a] && (chk_addr_a != RF_X0_ZERO);
    assign busy_b = !rst && pending[chk_addr_b] && (chk_addr_b != RF_X0_ZERO);

    always_comb begin
        rf_we      = 1'b0;
        rf_we_p    = 1'b0;
        rf_addr_d  = pipe_rd;
        rf_data_d  = pipe_data;
        rf_data_dp = pipe_data_p;
        if (!pipe_we) begin
            rf_addr_d  = head.rd;
            rf_data_d  = head.data;
            rf_data_dp = head.data_p;
        end
        if (!rst) begin
            if (pipe_we) begin
                rf_we   = 1'b1;
                rf_we_p = pipe_we_p;
            end else if (!fifo_empty) begin
                rf_we   = (head.rd != RF_X0_ZERO);
                rf_we_p = head.pair && (head.rd != RF_X0_ZERO);
            end
        end
    end

    // Bit 0 is never set, so x0 never reads as pending.
    always_comb begin
        pending_nxt = pending;
        if (pop) begin
            pending_nxt[head.rd] = 1'b0;
            if (head.pair) pending_nxt[get_rdp(head.rd)] = 1'b0;
        end
        if (iss_fire) begin
            if (iss_rd != RF_X0_ZERO) pending_nxt[iss_rd] = 1'b1;
            if (iss_pair) pending_nxt[get_rdp(iss_rd)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            outst   <= '0;
        end else begin
            pending <= pending_nxt;
            if (iss_fire && !pop)      outst <= outst + OW'(1);
            else if (!iss_fire && pop) outst <= outst - OW'(1);
        end
    end

`ifndef SYNT
    always @(posedge clk) begin
        if (!rst) begin
            if (iss_valid && iss_pair && iss_rd == RF_X31_T6)
                $fatal(1, "wb_arbiter: paired issue to x31");
            if (rsp_valid && rsp_pair && rsp_rd == RF_X31_T6)
                $fatal(1, "wb_arbiter: paired response to x31");
            if (pipe_we && (pending[pipe_rd] || (pipe_we_p && pending[get_rdp(pipe_rd)])))
                $fatal(1, "wb_arbiter: pipeline write to pending register x%0d", pipe_rd);
            if (push && outst == '0)
                $fatal(1, "wb_arbiter: response with nothing outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_ama_riscv_rf_wb_arbiter.sv
// Scoreboard bench: expected drained writes are queued at the response
// handshake and compared when the arbiter drives them onto the RF port.
module tb_ama_riscv_rf_wb_arbiter;
    import ama_riscv_rf_wb_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic        pipe_we_p;
    rf_addr_t    pipe_rd;
    arch_width_t pipe_data;
    arch_width_t pipe_data_p;
    logic        iss_valid;
    logic        iss_ready;
    rf_addr_t    iss_rd;
    logic        iss_pair;
    logic        rsp_valid;
    logic        rsp_ready;
    rf_addr_t    rsp_rd;
    logic        rsp_pair;
    arch_width_t rsp_data;
    arch_width_t rsp_data_p;
    rf_addr_t    chk_addr_a;
    rf_addr_t    chk_addr_b;
    logic        busy_a;
    logic        busy_b;
    logic        rf_we;
    logic        rf_we_p;
    rf_addr_t    rf_addr_d;
    arch_width_t rf_data_d;
    arch_width_t rf_data_dp;

    typedef struct {
        rf_addr_t    rd;
        logic        pair;
        arch_width_t d;
        arch_width_t dp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ama_riscv_rf_wb_arbiter #(
        .FIFO_DEPTH (4),
        .MAX_OUTST  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_we_p   (pipe_we_p),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .pipe_data_p (pipe_data_p),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rd      (iss_rd),
        .iss_pair    (iss_pair),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rd      (rsp_rd),
        .rsp_pair    (rsp_pair),
        .rsp_data    (rsp_data),
        .rsp_data_p  (rsp_data_p),
        .chk_addr_a  (chk_addr_a),
        .chk_addr_b  (chk_addr_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .rf_we       (rf_we),
        .rf_we_p     (rf_we_p),
        .rf_addr_d   (rf_addr_d),
        .rf_data_d   (rf_data_d),
        .rf_data_dp  (rf_data_dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pipeline writes must pass straight through; bubbles must carry the queued head.
    always @(negedge clk) begin
        if (!rst && pipe_we) begin
            check("pipe_pass", {rf_we, rf_we_p, rf_addr_d, rf_data_d},
                  {1'b1, pipe_we_p, pipe_rd, pipe_data});
        end else if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 80'(rf_addr_d), 80'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("drain_wr", {rf_we_p, rf_addr_d, rf_data_d, rf_data_dp},
                      {e.pair, e.rd, e.d, e.dp});
            end
        end
    end

    task automatic issue(input rf_addr_t rd, input logic pair, input logic exp_rdy, input string tag);
        iss_valid = 1'b1;
        iss_rd    = rd;
        iss_pair  = pair;
        @(negedge clk);
        check(tag, 80'(iss_ready), 80'(exp_rdy));
        step();
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_pair  = 1'b0;
    endtask

    task automatic send_rsp(input rf_addr_t rd, input logic pair, input arch_width_t d,
                            input arch_width_t dp, input string tag);
        logic hs;
        exp_t e;
        rsp_valid  = 1'b1;
        rsp_rd     = rd;
        rsp_pair   = pair;
        rsp_data   = d;
        rsp_data_p = dp;
        @(negedge clk);
        check(tag, 80'(rsp_ready), 80'd1);
        hs = rsp_ready;
        step();
        rsp_valid = 1'b0;
        if (hs && rd != RF_X0_ZERO) begin
            e = '{rd: rd, pair: pair, d: d, dp: dp};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check(tag, 80'(exp_q.size()), 80'd0);
    endtask

    initial begin
        rst = 1'b1;
        pipe_we = 1'b0; pipe_we_p = 1'b0; pipe_rd = '0; pipe_data = '0; pipe_data_p = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_pair = 1'b0;
        rsp_valid = 1'b0; rsp_rd = '0; rsp_pair = 1'b0; rsp_data = '0; rsp_data_p = '0;
        chk_addr_a = '0; chk_addr_b = '0;

        // reset state
        repeat (2) step();
        @(negedge clk);
        check("rst_outputs", {iss_ready, rsp_ready, rf_we, rf_we_p, busy_a, busy_b}, 80'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {iss_ready, rsp_ready, rf_we, busy_a}, 80'b1100);
        step();

        // idle pipe: single response drains next cycle
        chk_addr_a = 5'd5;
        issue(5'd5, 1'b0, 1'b1, "iss_x5");
        @(negedge clk);
        check("busy_x5_set", 80'(busy_a), 80'd1);
        step();
        send_rsp(5'd5, 1'b0, 32'hDEAD, 32'h0, "rsp_x5");
        @(negedge clk);
        check("x5_write", {rf_we, rf_addr_d, rf_data_d}, {1'b1, 5'd5, 32'hDEAD});
        step();
        @(negedge clk);
        check("busy_x5_clr", 80'(busy_a), 80'd0);
        step();

        // pipeline holds the port for 3 cycles; x7 waits in the FIFO
        issue(5'd7, 1'b0, 1'b1, "iss_x7");
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA5A5_0001;
        send_rsp(5'd7, 1'b0, 32'h7777, 32'h0, "rsp_x7");
        repeat (2) begin
            @(negedge clk);
            check("pipe_hold_addr", 80'(rf_addr_d), 80'd3);
            step();
            pipe_data = pipe_data + 32'd1;
        end
        pipe_we = 1'b0;
        @(negedge clk);
        check("x7_after_pipe", {rf_we, rf_addr_d, rf_data_d}, {1'b1, 5'd7, 32'h7777});
        step();

        // paired write
        chk_addr_a = 5'd10; chk_addr_b = 5'd11;
        issue(5'd10, 1'b1, 1'b1, "iss_x10p");
        @(negedge clk);
        check("busy_pair_set", {busy_a, busy_b}, 80'b11);
        step();
        send_rsp(5'd10, 1'b1, 32'h1111, 32'h2222, "rsp_x10p");
        @(negedge clk);
        check("pair_write", {rf_we, rf_we_p, rf_addr_d, busy_a, busy_b},
              {1'b1, 1'b1, 5'd10, 1'b1, 1'b1});
        step();
        @(negedge clk);
        check("busy_pair_clr", {busy_a, busy_b}, 80'b00);
        step();

        // outstanding limit, then FIFO full under continuous pipeline writes
        for (int i = 1; i <= 4; i++) issue(rf_addr_t'(i), 1'b0, 1'b1, "iss_fill");
        issue(5'd8, 1'b0, 1'b0, "iss_outst_blk");
        pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'hCAFE_0000;
        for (int i = 1; i <= 4; i++)
            send_rsp(rf_addr_t'(i), 1'b0, 32'h100 + 32'(i), 32'h0, "rsp_fill");
        @(negedge clk);
        check("rsp_full", 80'(rsp_ready), 80'd0);
        step();
        pipe_we = 1'b0;
        wait_drain("drain_fill");

        // WAW block and x0 issue
        issue(5'd6, 1'b0, 1'b1, "iss_x6");
        issue(5'd6, 1'b0, 1'b0, "iss_waw_blk");
        chk_addr_a = 5'd0;
        issue(5'd0, 1'b0, 1'b1, "iss_x0");
        @(negedge clk);
        check("busy_x0", 80'(busy_a), 80'd0);
        step();
        issue(5'd12, 1'b0, 1'b1, "iss_x12");
        issue(5'd13, 1'b0, 1'b1, "iss_x13");
        issue(5'd14, 1'b0, 1'b0, "iss_x0_counted");
        pipe_we = 1'b1;
        send_rsp(5'd6, 1'b0, 32'h6666, 32'h0, "rsp_x6");
        send_rsp(5'd0, 1'b0, 32'hBEEF, 32'h0, "rsp_x0");
        pipe_we = 1'b0;
        @(negedge clk);
        check("x6_write", {rf_we, rf_addr_d}, {1'b1, 5'd6});
        step();
        @(negedge clk);
        check("x0_drain_no_we", {rf_we, rf_we_p, rf_addr_d}, {1'b0, 1'b0, 5'd0});
        step();

        // reset with two entries queued drops everything
        chk_addr_a = 5'd12; chk_addr_b = 5'd13;
        pipe_we = 1'b1;
        send_rsp(5'd12, 1'b0, 32'hC0C0, 32'h0, "rsp_x12");
        send_rsp(5'd13, 1'b0, 32'hD0D0, 32'h0, "rsp_x13");
        pipe_we = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_drain", {rf_we, rf_we_p, busy_a, busy_b, iss_ready, rsp_ready}, 80'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", {rf_we, busy_a, busy_b, iss_ready, rsp_ready}, 80'b00011);
        step();
        issue(5'd12, 1'b0, 1'b1, "post_rst_iss_x12");
        issue(5'd13, 1'b0, 1'b1, "post_rst_iss_x13");
        issue(5'd1,  1'b0, 1'b1, "post_rst_iss_x1");
        issue(5'd2,  1'b0, 1'b1, "post_rst_iss_x2");
        issue(5'd3,  1'b0, 1'b0, "post_rst_outst_blk");
        @(negedge clk);
        check("post_rst_no_we", 80'(rf_we), 80'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
